rr_mux_arb: RTL and testbench

Parametrised N-channel, W-bit arbitrated multiplexer with valid/ready handshakes on every input and on the output. It generalises the fixed 4-input selector: instead of an external select, an internal round-robin (or fixed-priority) arbiter chooses among requesting channels and a registered output stage holds the winner until the consumer accepts it. It sits between several producers and one shared sink, for example a shared bus or result port.

---
 rtl/rr_mux_arb.sv | 51 +++++
 tb/tb_rr_mux_arb.sv | 109 ++++++++++
 2 files changed

// File: rtl/rr_mux_arb.sv
// rr_mux_arb: N-channel valid/ready multiplexer with round-robin or fixed-priority arbiter and registered output
module rr_mux_arb #(
  parameter int W = 4,
  parameter int N = 4,
  parameter bit FIXED_PRIO = 1'b0,
  localparam int CW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [CW-1:0]  out_ch,
  input  logic           out_ready
);
  logic [CW-1:0] ptr, g, kk;
  logic [W-1:0] chan [N];
  logic load;
  int k;
  for (genvar c = 0; c < N; c++) assign chan[c] = in_data[c*W +: W];
  // Scan from lowest priority to highest so the highest-priority requester is written last
  always_comb begin
    g = '0;
    k = 0;
    kk = '0;
    for (int i = N-1; i >= 0; i--) begin
      k = FIXED_PRIO ? i : (int'(ptr) + i) % N;
      kk = CW'(k);
      g = in_valid[kk] ? kk : g;
    end
  end
  assign load = !rst && (!out_valid || out_ready) && |in_valid;
  assign in_ready = load ? ({{(N-1){1'b0}}, 1'b1} << g) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data <= chan[g];
      out_ch <= g;
      ptr <= (g == CW'(N-1)) ? '0 : g + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_mux_arb.sv
// tb_rr_mux_arb: table-driven check of the round-robin instance plus a hand sequence for fixed priority
module tb_rr_mux_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] in_valid = '0;
  logic [15:0] in_data = '0;
  logic out_ready = 1'b0;
  logic [3:0] in_ready, f_ir;
  logic out_valid, f_ov;
  logic [3:0] out_data, f_od;
  logic [1:0] out_ch, f_och;
  int nvec = 0;
  int nerr = 0;
  typedef struct {
    logic r;
    logic [3:0] iv;
    logic [15:0] id;
    logic ordy;
    logic [3:0] ir;
    logic ov;
    logic [3:0] od;
    logic [1:0] och;
  } vec_t;
  vec_t q[$];
  always #5 clk = ~clk;
  rr_mux_arb #(.W(4), .N(4), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
  );
  rr_mux_arb #(.W(4), .N(4), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(f_ir),
    .out_valid(f_ov), .out_data(f_od), .out_ch(f_och), .out_ready(out_ready)
  );
  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic add(input logic r, input logic [3:0] iv, input logic [15:0] id, input logic ordy,
                     input logic [3:0] ir, input logic ov, input logic [3:0] od, input logic [1:0] och);
    q.push_back('{r, iv, id, ordy, ir, ov, od, och});
  endtask
  initial begin
    // rst iv     data     ordy  in_ready ov od  och
    add(1, 4'hF, 16'h8765, 1, 4'b0000, 0, 4'h0, 0);
    add(1, 4'hF, 16'h8765, 1, 4'b0000, 0, 4'h0, 0);
    add(0, 4'hF, 16'h8765, 1, 4'b0001, 1, 4'h5, 0);
    add(0, 4'hF, 16'h8765, 1, 4'b0010, 1, 4'h6, 1);
    add(0, 4'hF, 16'h8765, 1, 4'b0100, 1, 4'h7, 2);
    add(0, 4'hF, 16'h8765, 1, 4'b1000, 1, 4'h8, 3);
    add(0, 4'hF, 16'h8765, 1, 4'b0001, 1, 4'h5, 0);
    add(0, 4'hF, 16'h8765, 1, 4'b0010, 1, 4'h6, 1);
    add(0, 4'h4, 16'h0A00, 1, 4'b0100, 1, 4'hA, 2);
    add(0, 4'h3, 16'h0021, 1, 4'b0001, 1, 4'h1, 0);
    add(0, 4'h8, 16'hC000, 1, 4'b1000, 1, 4'hC, 3);
    add(0, 4'h0, 16'h0000, 1, 4'b0000, 0, 4'hC, 3);
    add(0, 4'h0, 16'h0000, 0, 4'b0000, 0, 4'hC, 3);
    add(0, 4'h1, 16'h0003, 1, 4'b0001, 1, 4'h3, 0);
    add(0, 4'hA, 16'h9040, 0, 4'b0000, 1, 4'h3, 0);
    add(0, 4'hA, 16'h9040, 0, 4'b0000, 1, 4'h3, 0);
    add(0, 4'hA, 16'h9040, 0, 4'b0000, 1, 4'h3, 0);
    add(0, 4'hA, 16'h9040, 1, 4'b0010, 1, 4'h4, 1);
    add(0, 4'h8, 16'h9000, 1, 4'b1000, 1, 4'h9, 3);
    add(0, 4'h1, 16'h0002, 1, 4'b0001, 1, 4'h2, 0);
    add(1, 4'hF, 16'h8765, 1, 4'b0000, 0, 4'h0, 0);
    add(0, 4'h9, 16'hB006, 1, 4'b0001, 1, 4'h6, 0);
    foreach (q[i]) begin
      @(negedge clk);
      rst = q[i].r;
      in_valid = q[i].iv;
      in_data = q[i].id;
      out_ready = q[i].ordy;
      #1 chk($sformatf("v%0d in_ready", i), int'(in_ready), int'(q[i].ir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), int'(out_valid), int'(q[i].ov));
      chk($sformatf("v%0d out_data", i), int'(out_data), int'(q[i].od));
      chk($sformatf("v%0d out_ch", i), int'(out_ch), int'(q[i].och));
    end
    // Fixed priority: ch0 always wins while requesting, then ch1 once ch0 drops
    @(negedge clk);
    rst = 1'b1;
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 4'hF;
    in_data = 16'h8765;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      #1 chk($sformatf("fp%0d in_ready", n), int'(f_ir), 1);
      @(posedge clk);
      #1;
      chk($sformatf("fp%0d out_ch", n), int'(f_och), 0);
      chk($sformatf("fp%0d out_data", n), int'(f_od), 5);
      @(negedge clk);
    end
    in_valid = 4'hE;
    #1 chk("fp_drop in_ready", int'(f_ir), 2);
    @(posedge clk);
    #1;
    chk("fp_drop out_ch", int'(f_och), 1);
    chk("fp_drop out_data", int'(f_od), 6);
    chk("fp_drop out_valid", int'(f_ov), 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
